// File: rtl/iob_2p_mem_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// iob_2p_mem_fifo_ctrl
//
// Synchronous FIFO controller that sequences one external two-port memory
// (one write port, one registered read port). The controller owns the
// read/write pointers and the occupancy level. It drives every memory
// strobe and address. It presents a push/pop interface to a producer and a
// consumer that share one clock.
//
// Ports
//   clk, rst_n      clock (rising edge) and synchronous active-low reset
//   push, w_data    producer write request and data
//   pop             consumer read request
//   r_data, r_valid read data (zero unless r_valid) one cycle after a pop
//   full, empty     level == depth / level == 0
//   almost_full     level >= AFULL_TH
//   almost_empty    level <= AEMPTY_TH
//   level           occupancy 0..depth
//   overflow        sticky: push attempted while full
//   underflow       sticky: pop attempted while empty
//   err_clr         clears overflow/underflow
//   mem_*           memory write/read port control, address and data
// ---------------------------------------------------------------------------
module iob_2p_mem_fifo_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int AFULL_TH  = 56,
    parameter int AEMPTY_TH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] w_data,
    input  logic              pop,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr,
    output logic              mem_w_en,
    output logic              mem_w_port_en,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_r_port_en,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam logic [ADDR_W:0] DEPTH_LVL  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AFULL_LVL  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_LVL = (ADDR_W+1)'(AEMPTY_TH);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_full;
    logic              r_empty;
    logic              r_afull;
    logic              r_aempty;
    logic              r_rvalid;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_push_acc;
    logic              w_pop_acc;
    logic [ADDR_W:0]   w_level_nxt;

    // Acceptance uses only the registered (pre-edge) flags. Reset masks the
    // strobes so that no memory access starts in a reset cycle.
    assign w_push_acc = rst_n && push && !r_full;
    assign w_pop_acc  = rst_n && pop  && !r_empty;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        w_level_nxt = r_level;
        if (w_push_acc && !w_pop_acc) begin
            w_level_nxt = r_level + (ADDR_W+1)'(1);
        end else if (w_pop_acc && !w_push_acc) begin
            w_level_nxt = r_level - (ADDR_W+1)'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Then every
    // register samples the pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_rvalid    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            // Pointers wrap naturally at 2**ADDR_W. Full/empty come from
            // level, so pointer equality never needs to be disambiguated.
            if (w_push_acc) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);

            // Flags are computed from the next level. They therefore change
            // in the same cycle as level.
            r_level  <= w_level_nxt;
            r_full   <= (w_level_nxt == DEPTH_LVL);
            r_empty  <= (w_level_nxt == '0);
            r_afull  <= (w_level_nxt >= AFULL_LVL);
            r_aempty <= (w_level_nxt <= AEMPTY_LVL);

            // The memory read port is registered. Its data therefore lines up
            // with this flag one cycle after the pop.
            r_rvalid <= w_pop_acc;

            // A new error in the same cycle takes priority over err_clr.
            if (push && r_full)     r_overflow  <= 1'b1;
            else if (err_clr)       r_overflow  <= 1'b0;
            if (pop && r_empty)     r_underflow <= 1'b1;
            else if (err_clr)       r_underflow <= 1'b0;
        end
    end

    // NOTE: the memory array lives outside this block and is never reset.
    // Only the control state above is reset, and stale words are unreachable
    // because level returns to zero.
    assign mem_w_en      = w_push_acc;
    assign mem_w_port_en = w_push_acc;
    assign mem_w_addr    = r_wr_ptr;
    assign mem_data_in   = w_data;
    assign mem_r_port_en = w_pop_acc;
    assign mem_r_addr    = r_rd_ptr;

    // The memory drives Z while its read port is idle. Gating keeps that Z
    // off the consumer bus.
    assign r_data       = r_rvalid ? mem_data_out : '0;
    assign r_valid      = r_rvalid;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
